// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - button input synchroniser and tick-based debouncer with edge pulses and press counter
module button_debouncer #(
    parameter int STABLE_TICKS = 4,
    parameter int ACTIVE_LOW   = 0,
    parameter int PRESS_W      = 8
) (
    input  logic               clk,
    input  logic               rst_a_p,
    input  logic               sample_tick,
    input  logic               btn_in,
    output logic               btn_level,
    output logic               btn_rise,
    output logic               btn_fall,
    output logic [PRESS_W-1:0] press_count
);

    localparam int              CNT_W   = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);
    localparam logic            INV     = (ACTIVE_LOW != 0);

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            state       <= ST_LOW;
            s1          <= 1'b0;
            s2          <= 1'b0;
            cnt         <= '0;
            btn_rise    <= 1'b0;
            btn_fall    <= 1'b0;
            press_count <= '0;
        end else begin
            s1       <= btn_in ^ INV;
            s2       <= s1;
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            // Any sample agreeing with the current level restarts the stability window.
            if (s2 == (state == ST_HIGH)) begin
                cnt <= '0;
            end else if (sample_tick) begin
                if (cnt == CNT_MAX) begin
                    cnt <= '0;
                    if (s2) begin
                        state       <= ST_HIGH;
                        btn_rise    <= 1'b1;
                        press_count <= press_count + 1'b1;
                    end else begin
                        state    <= ST_LOW;
                        btn_fall <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign btn_level = (state == ST_HIGH);

endmodule
